// File: rtl/instruction_fetcher.sv
// Instruction fetcher: reads opcodes from a combinational instruction
// memory and hands them to a consumer over a valid/ready handshake.
module instruction_fetcher #(
  parameter logic [7:0] END_OF_PROGRAM = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mem_address,
  output logic       mem_enable,
  input  logic [7:0] mem_data,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] pc;
  logic [7:0] pc_nx;
  logic [7:0] instr_nx;
  logic       ovf_nx;
  logic       last;

  assign last = (pc == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= 8'h00;
      instr    <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      instr    <= instr_nx;
      overflow <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    ovf_nx   = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_nx    = 8'h00;
          ovf_nx   = 1'b0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (mem_data == END_OF_PROGRAM) begin
          state_nx = DONE;
        end else begin
          instr_nx = mem_data;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // pc saturates at the top address; running off the end is an overflow
        unique case (1'b1)
          !instr_ready: state_nx = HOLD;
          last: begin
            ovf_nx   = 1'b1;
            state_nx = DONE;
          end
          default: begin
            pc_nx    = pc + 8'd1;
            state_nx = FETCH;
          end
        endcase
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_address = pc;
  assign mem_enable  = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule
